// File: rtl/hetic_arb_tree.sv
// Priority arbitration stage of the HETI interrupt controller: selects the best enabled pending
// line, offers it to the core, and pulses a pending-clear back to the line registers on ack.
module hetic_arb_tree #(
   parameter int unsigned NrIrqLines = 64,
   parameter int unsigned NrIrqPrios = 32,
   localparam int unsigned IrqWidth  = $clog2(NrIrqLines),
   localparam int unsigned PrioWidth = $clog2(NrIrqPrios)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NrIrqLines-1:0]           ie_i,
   input  logic [NrIrqLines-1:0]           ip_i,
   input  logic [NrIrqLines*PrioWidth-1:0] prio_i,
   input  logic [NrIrqLines-1:0]           heti_i,
   input  logic [NrIrqLines-1:0]           nest_i,
   input  logic [PrioWidth-1:0]            level_i,
   output logic                            irq_valid_o,
   output logic [IrqWidth-1:0]             irq_id_o,
   output logic [PrioWidth-1:0]            irq_prio_o,
   output logic                            irq_heti_o,
   output logic                            irq_nest_o,
   input  logic                            irq_ack_i,
   input  logic [IrqWidth-1:0]             irq_id_i,
   output logic [NrIrqLines-1:0]           clr_ip_o
);

   localparam int unsigned NumLeaves = 1 << IrqWidth;
   localparam logic [IrqWidth:0] NrLinesW = (IrqWidth + 1)'(NrIrqLines);

   typedef enum logic [1:0] {StArb, StClear, StSettle} state_e;

   // Leaves beyond NrIrqLines are zero-padded, so they are never candidates.
   logic [NumLeaves-1:0]           w_cand_pad;
   logic [NumLeaves-1:0]           w_heti_pad;
   logic [NumLeaves-1:0]           w_nest_pad;
   logic [NumLeaves*PrioWidth-1:0] w_prio_pad;

   assign w_cand_pad = NumLeaves'(ie_i & ip_i);
   assign w_heti_pad = NumLeaves'(heti_i);
   assign w_nest_pad = NumLeaves'(nest_i);
   assign w_prio_pad = (NumLeaves * PrioWidth)'(prio_i);

   logic                 w_node_found [NumLeaves];
   logic [IrqWidth-1:0]  w_node_id    [NumLeaves];
   logic [PrioWidth-1:0] w_node_prio  [NumLeaves];
   logic                 w_node_heti  [NumLeaves];
   logic                 w_node_nest  [NumLeaves];

   // In-place pairwise reduction; node i always holds the lower-index side, so ties keep it.
   always_comb begin
      for (int i = 0; i < NumLeaves; i++) begin
         w_node_found[i] = w_cand_pad[i];
         w_node_id[i]    = IrqWidth'(i);
         w_node_prio[i]  = w_prio_pad[i*PrioWidth +: PrioWidth];
         w_node_heti[i]  = w_heti_pad[i];
         w_node_nest[i]  = w_nest_pad[i];
      end
      for (int step = 1; step < NumLeaves; step = step * 2) begin
         for (int i = 0; i < NumLeaves; i = i + 2 * step) begin
            if (w_node_found[i+step] &&
                (!w_node_found[i] || (w_node_prio[i+step] > w_node_prio[i]))) begin
               w_node_found[i] = w_node_found[i+step];
               w_node_id[i]    = w_node_id[i+step];
               w_node_prio[i]  = w_node_prio[i+step];
               w_node_heti[i]  = w_node_heti[i+step];
               w_node_nest[i]  = w_node_nest[i+step];
            end
         end
      end
   end

   logic                 r_found;
   logic [IrqWidth-1:0]  r_id;
   logic [PrioWidth-1:0] r_prio;
   logic                 r_heti;
   logic                 r_nest;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_found <= 1'b0;
         r_id    <= '0;
         r_prio  <= '0;
         r_heti  <= 1'b0;
         r_nest  <= 1'b0;
      end else begin
         r_found <= w_node_found[0];
         r_id    <= w_node_id[0];
         r_prio  <= w_node_prio[0];
         r_heti  <= w_node_heti[0];
         r_nest  <= w_node_nest[0];
      end
   end

   state_e                r_state;
   logic [NrIrqLines-1:0] r_clr_ip;
   logic                  w_ack_in_range;

   assign w_ack_in_range = ({1'b0, irq_id_i} < NrLinesW);

   // SETTLE gives the winner register one edge to see the cleared pending bit.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state  <= StArb;
         r_clr_ip <= '0;
      end else begin
         r_clr_ip <= '0;
         unique case (r_state)
            StArb: begin
               if (irq_ack_i && w_ack_in_range) begin
                  r_clr_ip <= NrIrqLines'(1) << irq_id_i;
                  r_state  <= StClear;
               end
            end
            StClear:  r_state <= StSettle;
            StSettle: r_state <= StArb;
            default:  r_state <= StArb;
         endcase
      end
   end

   assign irq_valid_o = (r_state == StArb) & r_found & (r_prio > level_i);
   assign irq_id_o    = r_id;
   assign irq_prio_o  = r_prio;
   assign irq_heti_o  = r_heti;
   assign irq_nest_o  = r_nest;
   assign clr_ip_o    = r_clr_ip;

endmodule

// File: tb/tb_hetic_arb_tree.sv
// Bench for hetic_arb_tree: directed scenarios plus random traffic against a linear-scan
// reference model that also plays the line registers (pending bits clear on the clear pulse).
module tb_hetic_arb_tree;

   localparam int unsigned NrIrqLines = 48;
   localparam int unsigned NrIrqPrios = 32;
   localparam int unsigned IrqWidth   = 6;
   localparam int unsigned PrioWidth  = 5;

   logic                            clk = 1'b0;
   logic                            rst_n;
   logic [NrIrqLines-1:0]           ie, ip, heti, nest;
   logic [NrIrqLines*PrioWidth-1:0] prio;
   logic [PrioWidth-1:0]            level;
   logic                            ack;
   logic [IrqWidth-1:0]             ack_id;
   logic                            irq_valid;
   logic [IrqWidth-1:0]             irq_id;
   logic [PrioWidth-1:0]            irq_prio;
   logic                            irq_heti, irq_nest;
   logic [NrIrqLines-1:0]           clr_ip;

   always #5 clk = ~clk;

   hetic_arb_tree #(
      .NrIrqLines (NrIrqLines),
      .NrIrqPrios (NrIrqPrios)
   ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .ie_i        (ie),
      .ip_i        (ip),
      .prio_i      (prio),
      .heti_i      (heti),
      .nest_i      (nest),
      .level_i     (level),
      .irq_valid_o (irq_valid),
      .irq_id_o    (irq_id),
      .irq_prio_o  (irq_prio),
      .irq_heti_o  (irq_heti),
      .irq_nest_o  (irq_nest),
      .irq_ack_i   (ack),
      .irq_id_i    (ack_id),
      .clr_ip_o    (clr_ip)
   );

   // Reference state: winner seen at the last edge, ack phase (0 idle, 1 clearing, 2 settling).
   logic                  m_found = 1'b0;
   logic [IrqWidth-1:0]   m_id    = '0;
   logic [PrioWidth-1:0]  m_prio  = '0;
   logic                  m_heti  = 1'b0;
   logic                  m_nest  = 1'b0;
   int                    m_phase = 0;
   logic [NrIrqLines-1:0] m_clr   = '0;

   int n_checks = 0;
   int n_errors = 0;
   int pulses;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic exp_valid;
      exp_valid = (m_phase == 0) && m_found && (m_prio > level);
      check("valid", 64'(irq_valid), 64'(exp_valid));
      check("id",    64'(irq_id),    64'(m_id));
      check("prio",  64'(irq_prio),  64'(m_prio));
      check("heti",  64'(irq_heti),  64'(m_heti));
      check("nest",  64'(irq_nest),  64'(m_nest));
      check("clr",   64'(clr_ip),    64'(m_clr));
   endtask

   task automatic set_prio(input int line, input int p);
      prio[line*PrioWidth +: PrioWidth] = PrioWidth'(p);
   endtask

   // One clock edge: predict from pre-edge inputs, then compare just after the edge.
   task automatic tick();
      logic                  f, h, n;
      logic [IrqWidth-1:0]   id;
      logic [PrioWidth-1:0]  p;
      logic [NrIrqLines-1:0] nclr, ip_next;
      int                    nph;
      f = 1'b0; id = '0; p = '0; h = 1'b0; n = 1'b0;
      for (int i = 0; i < NrIrqLines; i++) begin
         if (ie[i] && ip[i] && (!f || prio[i*PrioWidth +: PrioWidth] > p)) begin
            f  = 1'b1;
            id = IrqWidth'(i);
            p  = prio[i*PrioWidth +: PrioWidth];
            h  = heti[i];
            n  = nest[i];
         end
      end
      ip_next = ip & ~m_clr;
      nclr = '0;
      nph  = 0;
      if (!rst_n) begin
         f = 1'b0; id = '0; p = '0; h = 1'b0; n = 1'b0;
      end else if (m_phase == 0) begin
         if (ack && (int'(ack_id) < NrIrqLines)) begin
            nph  = 1;
            nclr = NrIrqLines'(1) << ack_id;
         end
      end else if (m_phase == 1) begin
         nph = 2;
      end
      @(posedge clk);
      #1;
      m_found = f; m_id = id; m_prio = p; m_heti = h; m_nest = n;
      m_phase = nph;
      m_clr   = nclr;
      ip      = ip_next;
      check_outputs();
   endtask

   task automatic clear_inputs();
      ie = '0; ip = '0; heti = '0; nest = '0; prio = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      level = '0; ack = 1'b0; ack_id = '0;
      tick();
      tick();
      rst_n = 1'b1;

      // Single line, then same-cycle masking by level.
      ie[5] = 1'b1; ip[5] = 1'b1; set_prio(5, 3);
      tick();
      check("single_id", 64'(irq_id), 64'd5);
      check("single_valid", 64'(irq_valid), 64'd1);
      level = 5'd3;
      #1;
      check("level_same_cycle", 64'(irq_valid), 64'd0);
      level = '0;

      // Tie at prio 4 between lines 7 and 2; line 40 dominates.
      clear_inputs();
      ie[7] = 1'b1; ip[7] = 1'b1; set_prio(7, 4);
      ie[2] = 1'b1; ip[2] = 1'b1; set_prio(2, 4);
      ie[40] = 1'b1; ip[40] = 1'b1; set_prio(40, 9);
      tick();
      check("tree_max", 64'(irq_id), 64'd40);
      ip[40] = 1'b0;
      tick();
      check("tree_tie", 64'(irq_id), 64'd2);
      ip[40] = 1'b1;
      tick();

      // Ack flow on line 40.
      ack = 1'b1; ack_id = 6'd40;
      tick();
      ack = 1'b0;
      check("ack_clr_pulse", 64'(clr_ip), 64'(NrIrqLines'(1) << 40));
      check("ack_valid_e0", 64'(irq_valid), 64'd0);
      tick();
      check("ack_clr_drop", 64'(clr_ip), 64'd0);
      check("ack_valid_e1", 64'(irq_valid), 64'd0);
      tick();
      check("ack_next_id", 64'(irq_id), 64'd2);
      check("ack_next_valid", 64'(irq_valid), 64'd1);

      // Ack held through CLEAR and SETTLE: only one pulse.
      ip[40] = 1'b1;
      tick();
      pulses = 0;
      ack = 1'b1; ack_id = 6'd40;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (clr_ip != '0) pulses++;
      end
      ack = 1'b0;
      check("single_pulse", 64'(pulses), 64'd1);

      // Out-of-range id is ignored and the request stays up.
      ack = 1'b1; ack_id = 6'd50;
      tick();
      ack = 1'b0;
      check("oor_clr", 64'(clr_ip), 64'd0);
      check("oor_valid", 64'(irq_valid), 64'd1);

      // Winner flags.
      clear_inputs();
      ie[0] = 1'b1; ip[0] = 1'b1; set_prio(0, 1); heti[0] = 1'b1; nest[1] = 1'b1;
      tick();
      check("flag_heti", 64'(irq_heti), 64'd1);
      check("flag_nest", 64'(irq_nest), 64'd0);

      // Reset while in CLEAR.
      ack = 1'b1; ack_id = 6'd0;
      tick();
      ack = 1'b0;
      check("rst_pre_clr", 64'(clr_ip), 64'd1);
      rst_n = 1'b0;
      tick();
      check("rst_clr", 64'(clr_ip), 64'd0);
      check("rst_valid", 64'(irq_valid), 64'd0);
      rst_n = 1'b1;
      ip[0] = 1'b1;
      tick();
      check("rst_fresh", 64'(irq_valid), 64'd1);

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            ie   = NrIrqLines'({$urandom(), $urandom()});
            ip   = NrIrqLines'({$urandom(), $urandom()});
            heti = NrIrqLines'({$urandom(), $urandom()});
            nest = NrIrqLines'({$urandom(), $urandom()});
            for (int i = 0; i < NrIrqLines; i++) begin
               set_prio(i, ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) :
                                                         $urandom_range(0, NrIrqPrios - 1));
            end
         end else if ($urandom_range(0, 1) == 0) begin
            ip[$urandom_range(0, NrIrqLines - 1)] = 1'b1;
         end
         level  = PrioWidth'($urandom_range(0, 8));
         ack    = ($urandom_range(0, 3) == 0);
         ack_id = ($urandom_range(0, 1) == 0) ? m_id : IrqWidth'($urandom_range(0, 63));
         rst_n  = ($urandom_range(0, 60) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
